regfile_write_buffer: RTL and testbench

//  Write-side initiator for the 32-entry register file. Accepts write-back

---
 rtl/regfile_write_buffer.sv | 73 +++++++
 tb/tb_regfile_write_buffer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: FIFO-buffered write port for the register file,
// with read-after-write hazard flags for both read addresses.
module regfile_write_buffer #(
   parameter int N         = 32,
   parameter int DEPTH     = 4,
   parameter int DROP_ZERO = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_valid_i,
   output logic                     wr_ready_o,
   input  logic [4:0]               wr_addr_i,
   input  logic [N-1:0]             wr_data_i,
   input  logic                     stall_i,
   output logic                     Reg_Write_o,
   output logic [4:0]               Write_Register_o,
   output logic [N-1:0]             Write_Data_o,
   input  logic [4:0]               Read_Register_1_i,
   input  logic [4:0]               Read_Register_2_i,
   output logic                     hazard_1_o,
   output logic                     hazard_2_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [4:0]   r_addr [DEPTH];
   logic [N-1:0] r_data [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_count;
   logic w_drop, w_push, w_pop, w_hit1, w_hit2;
   assign w_drop     = (DROP_ZERO != 0) && (wr_addr_i == 5'd0);
   assign wr_ready_o = r_count != FULL;
   assign w_push     = wr_valid_i && wr_ready_o && !w_drop;
   assign w_pop      = (r_count != '0) && !stall_i;
   assign count_o    = r_count;
   // Storage carries no reset; validity is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wp] <= wr_addr_i;
         r_data[r_wp] <= wr_data_i;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp             <= '0;
         r_rp             <= '0;
         r_count          <= '0;
         Reg_Write_o      <= 1'b0;
         Write_Register_o <= '0;
         Write_Data_o     <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_count     <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         Reg_Write_o <= w_pop;
         if (w_pop) begin
            Write_Register_o <= r_addr[r_rp];
            Write_Data_o     <= r_data[r_rp];
         end
      end
   end
   // Entry rp+i is live when i < count; the output stage counts while its write is in flight.
   always_comb begin
      w_hit1 = Reg_Write_o && (Write_Register_o == Read_Register_1_i);
      w_hit2 = Reg_Write_o && (Write_Register_o == Read_Register_2_i);
      for (int i = 0; i < DEPTH; i++) begin
         if ((AW+1)'(i) < r_count && r_addr[r_rp + AW'(i)] == Read_Register_1_i) w_hit1 = 1'b1;
         if ((AW+1)'(i) < r_count && r_addr[r_rp + AW'(i)] == Read_Register_2_i) w_hit2 = 1'b1;
      end
   end
   assign hazard_1_o = w_hit1 && !((DROP_ZERO != 0) && (Read_Register_1_i == 5'd0));
   assign hazard_2_o = w_hit2 && !((DROP_ZERO != 0) && (Read_Register_2_i == 5'd0));
endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb_regfile_write_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the write buffer.
module tb_regfile_write_buffer;
   localparam int DEPTH = 4;
   logic clk = 1'b0, reset = 1'b0;
   logic wr_valid_i = 1'b0, wr_ready_o, stall_i = 1'b0, Reg_Write_o;
   logic [4:0] wr_addr_i = '0, Write_Register_o, Read_Register_1_i = '0, Read_Register_2_i = '0;
   logic [31:0] wr_data_i = '0, Write_Data_o;
   logic hazard_1_o, hazard_2_o;
   logic [2:0] count_o;
   int n_checks = 0, n_fail = 0;
   logic [36:0] q[$];
   logic m_rw = 1'b0;
   logic [4:0] m_wreg = '0;
   logic [31:0] m_wdata = '0;

   regfile_write_buffer #(.N(32), .DEPTH(DEPTH), .DROP_ZERO(1)) dut (
      .clk(clk), .reset(reset), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .stall_i(stall_i),
      .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o), .Write_Data_o(Write_Data_o),
      .Read_Register_1_i(Read_Register_1_i), .Read_Register_2_i(Read_Register_2_i),
      .hazard_1_o(hazard_1_o), .hazard_2_o(hazard_2_o), .count_o(count_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic mhaz(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i][36:32] == r) return 1'b1;
      return m_rw && (m_wreg == r);
   endfunction

   task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic s, input logic [4:0] r1, input logic [4:0] r2);
      logic rdy;
      wr_valid_i = v; wr_addr_i = a; wr_data_i = d; stall_i = s;
      Read_Register_1_i = r1; Read_Register_2_i = r2;
      #1;
      rdy = q.size() < DEPTH;
      chk("ready", 64'(wr_ready_o), 64'(rdy));
      chk("haz1", 64'(hazard_1_o), 64'(mhaz(r1)));
      chk("haz2", 64'(hazard_2_o), 64'(mhaz(r2)));
      @(posedge clk);
      if (q.size() > 0 && !s) begin
         {m_wreg, m_wdata} = q.pop_front();
         m_rw = 1'b1;
      end else m_rw = 1'b0;
      if (v && rdy && a != 5'd0) q.push_back({a, d});
      #1;
      chk("rw", 64'(Reg_Write_o), 64'(m_rw));
      chk("wreg", 64'(Write_Register_o), 64'(m_wreg));
      chk("wdata", 64'(Write_Data_o), 64'(m_wdata));
      chk("count", 64'(count_o), 64'(q.size()));
   endtask

   task automatic do_reset();
      wr_valid_i = 1'b0; stall_i = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_rw", 64'(Reg_Write_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_wreg", 64'(Write_Register_o), 64'd0);
      chk("rst_wdata", 64'(Write_Data_o), 64'd0);
      q.delete(); m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 64'(wr_ready_o), 64'd1);
   endtask

   initial begin
      do_reset();
      // single write latency
      step(1, 5, 32'hDEADBEEF, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("t1_rw", 64'(Reg_Write_o), 64'd1);
      chk("t1_data", 64'(Write_Data_o), 64'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0);
      chk("t1_rw_off", 64'(Reg_Write_o), 64'd0);
      // fill under stall, fifth request held, ordered drain
      for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 'h11), 1, 0, 0);
      chk("t2_full", 64'(count_o), 64'd4);
      step(1, 9, 32'h99, 1, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         step(0, 0, 0, 0, 0, 0);
         chk("t2_order", 64'(Write_Register_o), 64'(i));
      end
      step(0, 0, 0, 0, 0, 0);
      // address zero dropped
      step(1, 0, 32'hFFFFFFFF, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("t3_cnt", 64'(count_o), 64'd0);
      // same-address hazard, later write wins
      step(1, 7, 32'hA, 1, 0, 7);
      step(1, 7, 32'hB, 1, 0, 7);
      step(0, 0, 0, 0, 0, 7);
      step(0, 0, 0, 0, 0, 7);
      chk("t4_last", 64'(Write_Data_o), 64'hB);
      step(0, 0, 0, 0, 0, 7);
      // full rate streaming
      for (int i = 0; i < 20; i++) begin
         step(1, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0);
         chk("t5_le1", 64'(count_o <= 3'd1), 64'd1);
      end
      step(0, 0, 0, 0, 0, 0);
      // reset with entries pending
      for (int i = 0; i < 3; i++) step(1, 5'(i + 10), $urandom, 1, 0, 0);
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
      // random traffic with varying stall pressure
      for (int i = 0; i < 3000; i++) begin
         int sp;
         sp = (i / 300) % 3 == 0 ? 80 : ((i / 300) % 3 == 1 ? 20 : 50);
         step($urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < sp, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (i == 1500) do_reset();
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
